// File: rtl/irq_msg_issuer.sv
// Round-robin interrupt message issuer: takes level requests from the edge-capture shim,
// issues one vector per request on a valid/ready port and returns a one-cycle ack.
module irq_msg_issuer #(
  parameter int WIDTH       = 16,
  parameter int VEC_W       = 8,
  parameter int VECTOR_BASE = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [WIDTH-1:0]   irq_req,
  output logic [WIDTH-1:0]   irq_ack,
  input  logic [WIDTH-1:0]   irq_mask,
  output logic               msg_valid,
  output logic [VEC_W-1:0]   msg_vector,
  input  logic               msg_ready,
  output logic [WIDTH-1:0]   irq_pending,
  output logic               busy,
  output logic [31:0]        msg_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W:0]   WIDTH_L = (IDX_W + 1)'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [WIDTH-1:0]   irq_ack_q;
  logic               msg_valid_q;
  logic [VEC_W-1:0]   msg_vector_q;
  logic [WIDTH-1:0]   irq_pending_q;
  logic               busy_q;
  logic [31:0]        msg_count_q;

  logic [WIDTH-1:0]   elig;
  logic [WIDTH-1:0]   elig_rot;
  logic [IDX_W-1:0]   pick_off;
  logic               pick_found;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W-1:0]   pick_idx;
  logic [VEC_W-1:0]   msg_vector_d;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [WIDTH-1:0]   irq_ack_d;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    elig       = irq_req & ~irq_mask;
    elig_rot   = WIDTH'({elig, elig} >> rr_ptr_q);
    pick_off   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!pick_found && elig_rot[k]) begin
        pick_found = 1'b1;
        pick_off   = IDX_W'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    if (pick_sum >= WIDTH_L) begin
      pick_sum = pick_sum - WIDTH_L;
    end
    pick_idx     = pick_sum[IDX_W-1:0];
    msg_vector_d = VEC_W'(VECTOR_BASE) + VEC_W'(pick_idx);
    rr_ptr_d     = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
    irq_ack_d    = WIDTH'(1) << grant_idx_q;
  end

  // NOTE: the reset is synchronous, so it is tested inside the clocked block with no rstn in
  // the sensitivity list; every register, including the FSM outputs, gets a value there.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      irq_ack_q     <= '0;
      msg_valid_q   <= 1'b0;
      msg_vector_q  <= '0;
      irq_pending_q <= '0;
      busy_q        <= 1'b0;
      msg_count_q   <= '0;
    end else begin
      irq_pending_q <= elig;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_idx_q  <= pick_idx;
            msg_vector_q <= msg_vector_d;
            msg_valid_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          // The message is frozen here; only acceptance moves it on.
          if (msg_ready) begin
            msg_valid_q <= 1'b0;
            irq_ack_q   <= irq_ack_d;
            rr_ptr_q    <= rr_ptr_d;
            msg_count_q <= msg_count_q + 32'd1;
            state_q     <= ACK;
          end
        end
        ACK: begin
          irq_ack_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          irq_ack_q   <= '0;
          msg_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign irq_ack     = irq_ack_q;
  assign msg_valid   = msg_valid_q;
  assign msg_vector  = msg_vector_q;
  assign irq_pending = irq_pending_q;
  assign busy        = busy_q;
  assign msg_count   = msg_count_q;

endmodule
